// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-mapped bus slave: timer register map,
// control/status bit positions and the decode region type.
package mem_bus_pkg;

  localparam logic [3:0] TMR_CTRL   = 4'h0;
  localparam logic [3:0] TMR_COUNT  = 4'h4;
  localparam logic [3:0] TMR_LIMIT  = 4'h8;
  localparam logic [3:0] TMR_STATUS = 4'hC;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_IE     = 1;
  localparam int unsigned CTRL_AUTO   = 2;
  localparam int unsigned STATUS_PEND = 0;

  localparam logic [31:0] DEFAULT_UNMAPPED_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    RGN_NONE,
    RGN_RAM,
    RGN_TMR
  } region_e;

  function automatic logic [31:0] merge_be(input logic [31:0] old,
                                           input logic [31:0] data,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = data[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_bus_timer.sv
// Timer register block: CTRL/COUNT/LIMIT/STATUS with a free-running counter,
// terminal-count detection and a registered level interrupt.
module mem_bus_timer
  import mem_bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic [1:0]  sel,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [2:0]  ctrl;
  logic [31:0] count;
  logic [31:0] limit;
  logic        pend;

  logic [3:0]  reg_off;
  logic        terminal;
  logic        w1c;
  logic [2:0]  ctrl_w;
  logic [31:0] count_w;
  logic [31:0] limit_w;

  always_comb begin
    reg_off  = {sel, 2'b00};
    terminal = ctrl[CTRL_EN] && (count == limit);
    ctrl_w   = be[0] ? wdata[2:0] : ctrl;
    count_w  = merge_be(count, wdata, be);
    limit_w  = merge_be(limit, wdata, be);
    w1c      = wr && (reg_off == TMR_STATUS) && be[0] && wdata[STATUS_PEND];
    case (reg_off)
      TMR_CTRL:   rdata = {29'b0, ctrl};
      TMR_COUNT:  rdata = count;
      TMR_LIMIT:  rdata = limit;
      TMR_STATUS: rdata = {31'b0, pend};
      default:    rdata = '0;
    endcase
  end

  // Bus writes are applied after the counter update so they take priority;
  // a pending set on terminal count overrides a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl  <= '0;
      count <= '0;
      limit <= '0;
      pend  <= 1'b0;
      irq   <= 1'b0;
    end else begin
      irq <= pend & ctrl[CTRL_IE];
      if (terminal) begin
        pend <= 1'b1;
        if (ctrl[CTRL_AUTO]) count <= '0;
        else                 ctrl[CTRL_EN] <= 1'b0;
      end else if (ctrl[CTRL_EN]) begin
        count <= count + 32'd1;
      end
      if (w1c && !terminal)                 pend  <= 1'b0;
      if (wr && (reg_off == TMR_CTRL))      ctrl  <= ctrl_w;
      if (wr && (reg_off == TMR_COUNT))     count <= count_w;
      if (wr && (reg_off == TMR_LIMIT))     limit <= limit_w;
    end
  end

endmodule

// File: rtl/mem_bus_slave.sv
// Memory-mapped slave: byte-lane writable on-chip RAM, fixed-latency read
// pipeline and a timer block driving the cpu interrupt.
module mem_bus_slave
  import mem_bus_pkg::*;
#(
  parameter logic [31:0] MEM_BASE      = 32'h00000000,
  parameter int unsigned MEM_AW        = 12,
  parameter int unsigned RD_LATENCY    = 2,
  parameter logic [31:0] TMR_BASE      = 32'hAFFFFFE0,
  parameter logic [31:0] UNMAPPED_DATA = DEFAULT_UNMAPPED_DATA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        irq
);

  localparam int unsigned DEPTH = 1 << MEM_AW;

  region_e            rgn;
  logic [MEM_AW-1:0]  widx;
  logic [31:0]        rsrc;
  logic [31:0]        tmr_rdata;
  logic [31:0]        mem [DEPTH];
  logic [RD_LATENCY-1:0] vld;
  logic [31:0]        dat [RD_LATENCY];
  logic               addr_unused;

  assign addr_unused = &{1'b0, address[1:0]};

  always_comb begin
    widx = address[MEM_AW+1:2];
    rgn  = RGN_NONE;
    if (address[31:MEM_AW+2] == MEM_BASE[31:MEM_AW+2]) rgn = RGN_RAM;
    else if (address[31:4] == TMR_BASE[31:4])          rgn = RGN_TMR;
  end

  always_ff @(posedge clk) begin
    if (write && (rgn == RGN_RAM)) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byteenable[i]) mem[widx][8*i +: 8] <= writedata[8*i +: 8];
      end
    end
  end

  mem_bus_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .wr    (write && (rgn == RGN_TMR)),
    .sel   (address[3:2]),
    .wdata (writedata),
    .be    (byteenable),
    .rdata (tmr_rdata),
    .irq   (irq)
  );

  // RAM is read combinationally in the accept cycle, so a same-cycle write
  // to the same word is only visible to later reads.
  always_comb begin
    case (rgn)
      RGN_RAM: rsrc = mem[widx];
      RGN_TMR: rsrc = tmr_rdata;
      default: rsrc = UNMAPPED_DATA;
    endcase
  end

  // Data stages load only behind a valid, so the last stage holds its value
  // between returns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) dat[i] <= '0;
    end else begin
      vld[0] <= read;
      if (read) dat[0] <= rsrc;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

  assign readdatavalid = vld[RD_LATENCY-1];
  assign readdata      = dat[RD_LATENCY-1];

endmodule
